// File: rtl/ap_ctrl_multi_monitor_if.sv
// ap_ctrl_multi_monitor_if: per-channel ap_ctrl handshakes, status outputs and read port of the monitor
interface ap_ctrl_multi_monitor_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic [NUM_CH-1:0] ap_start_i, ap_ready_i, ap_done_i, ap_continue_i;
  logic [NUM_CH-1:0] busy_o, err_o;
  logic              rd_en_i;
  logic [CH_W-1:0]   rd_ch_i;
  logic [2:0]        rd_sel_i;
  logic              rd_valid_o;
  logic [CNT_W-1:0]  rd_data_o;
  modport master (
    output ap_start_i, ap_ready_i, ap_done_i, ap_continue_i, rd_en_i, rd_ch_i, rd_sel_i,
    input  busy_o, err_o, rd_valid_o, rd_data_o
  );
  modport slave (
    input  ap_start_i, ap_ready_i, ap_done_i, ap_continue_i, rd_en_i, rd_ch_i, rd_sel_i,
    output busy_o, err_o, rd_valid_o, rd_data_o
  );
endinterface

// File: rtl/ap_ctrl_multi_monitor.sv
// ap_ctrl_multi_monitor: per-channel ap_ctrl statistics and latency monitor; DF_MON_MINMAX_EN adds min/max latency
module ap_ctrl_multi_monitor #(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 32,
  parameter int MAX_OUTST = 8
) (
  input logic                    clock,
  input logic                    reset_n,
  input logic                    finish_i,
  input logic                    clear_i,
  ap_ctrl_multi_monitor_if.slave mon
);
  localparam int AW = $clog2(MAX_OUTST);
  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, STALLED = 2'd2} state_t;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic              frozen_q, frozen_d;
  logic [CNT_W-1:0]  ts_q [NUM_CH][MAX_OUTST];
  logic [AW-1:0]     wp_q [NUM_CH], wp_d [NUM_CH], rp_q [NUM_CH], rp_d [NUM_CH];
  logic [AW:0]       oc_q [NUM_CH], oc_d [NUM_CH];
  logic [CNT_W-1:0]  sc_q [NUM_CH], sc_d [NUM_CH], dc_q [NUM_CH], dc_d [NUM_CH];
  logic [CNT_W-1:0]  stc_q [NUM_CH], stc_d [NUM_CH], ll_q [NUM_CH], ll_d [NUM_CH], lat [NUM_CH];
  state_t            st_q [NUM_CH], st_d [NUM_CH];
  logic [NUM_CH-1:0] err_q, err_d, acc, cmp, stl, emp, ful, push, pop, vcmp;
  logic              rd_valid_q;
  logic [CNT_W-1:0]  rd_data_q, rd_d;
`ifdef DF_MON_MINMAX_EN
  logic [CNT_W-1:0]  mn_q [NUM_CH], mn_d [NUM_CH], mx_q [NUM_CH], mx_d [NUM_CH];
`endif
  // Events are masked while frozen or clearing so no statistic moves
  assign acc = (frozen_q || clear_i) ? '0 : mon.ap_start_i & mon.ap_ready_i;
  assign cmp = (frozen_q || clear_i) ? '0 : mon.ap_done_i & mon.ap_continue_i;
  assign stl = (frozen_q || clear_i) ? '0 : mon.ap_done_i & ~mon.ap_continue_i;
  assign timer_d = clear_i ? '0 : timer_q + CNT_W'(1);
  assign frozen_d = !clear_i && (frozen_q || finish_i);
  assign mon.err_o = err_q;
  assign mon.rd_valid_o = rd_valid_q;
  assign mon.rd_data_o = rd_data_q;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign emp[i] = oc_q[i] == '0;
    assign ful[i] = oc_q[i] == (AW+1)'(MAX_OUTST);
    assign pop[i] = cmp[i] && !emp[i];
    // An accept completing in the same cycle on an empty FIFO is a zero-latency pass-through
    assign vcmp[i] = cmp[i] && (!emp[i] || acc[i]);
    assign push[i] = acc[i] && !(cmp[i] && emp[i]) && !(ful[i] && !pop[i]);
    assign lat[i] = emp[i] ? '0 : timer_q - ts_q[i][rp_q[i]];
    assign wp_d[i] = clear_i ? '0 : wp_q[i] + AW'(push[i]);
    assign rp_d[i] = clear_i ? '0 : rp_q[i] + AW'(pop[i]);
    assign oc_d[i] = clear_i ? '0 : oc_q[i] + (AW+1)'(push[i]) - (AW+1)'(pop[i]);
    assign sc_d[i] = clear_i ? '0 : sc_q[i] + CNT_W'(acc[i] && sc_q[i] != '1);
    assign dc_d[i] = clear_i ? '0 : dc_q[i] + CNT_W'(vcmp[i] && dc_q[i] != '1);
    assign stc_d[i] = clear_i ? '0 : stc_q[i] + CNT_W'(stl[i] && stc_q[i] != '1);
    assign ll_d[i] = clear_i ? '0 : vcmp[i] ? lat[i] : ll_q[i];
    assign err_d[i] = !clear_i && (err_q[i] || (cmp[i] && emp[i] && !acc[i]) || (acc[i] && ful[i] && !pop[i]));
    assign st_d[i] = clear_i ? IDLE :
                     st_q[i] == IDLE ? (push[i] ? ACTIVE : IDLE) :
                     vcmp[i] ? (oc_d[i] == '0 ? IDLE : ACTIVE) :
                     stl[i] ? STALLED : st_q[i];
    assign mon.busy_o[i] = st_q[i] != IDLE;
`ifdef DF_MON_MINMAX_EN
    assign mn_d[i] = clear_i ? '1 : (vcmp[i] && lat[i] < mn_q[i]) ? lat[i] : mn_q[i];
    assign mx_d[i] = clear_i ? '0 : (vcmp[i] && lat[i] > mx_q[i]) ? lat[i] : mx_q[i];
`endif
  end
  // Read mux looks at next-state values so a read returns the post-edge view
  always_comb begin
    rd_d = '0;
    if (int'(mon.rd_ch_i) < NUM_CH)
      case (mon.rd_sel_i)
        3'd0: rd_d = sc_d[mon.rd_ch_i];
        3'd1: rd_d = dc_d[mon.rd_ch_i];
        3'd2: rd_d = ll_d[mon.rd_ch_i];
        3'd3: rd_d = stc_d[mon.rd_ch_i];
`ifdef DF_MON_MINMAX_EN
        3'd4: rd_d = mn_d[mon.rd_ch_i];
        3'd5: rd_d = mx_d[mon.rd_ch_i];
`endif
        3'd6: rd_d = CNT_W'(oc_d[mon.rd_ch_i]);
        3'd7: rd_d = CNT_W'({st_d[mon.rd_ch_i], err_d[mon.rd_ch_i], st_d[mon.rd_ch_i] != IDLE});
        default: rd_d = '0;
      endcase
  end
  // All monitor state, timestamp FIFOs, channel FSMs and the read port
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      timer_q <= '0;
      frozen_q <= 1'b0;
      err_q <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        wp_q[c] <= '0;
        rp_q[c] <= '0;
        oc_q[c] <= '0;
        sc_q[c] <= '0;
        dc_q[c] <= '0;
        stc_q[c] <= '0;
        ll_q[c] <= '0;
        st_q[c] <= IDLE;
`ifdef DF_MON_MINMAX_EN
        mn_q[c] <= '1;
        mx_q[c] <= '0;
`endif
        for (int k = 0; k < MAX_OUTST; k++) ts_q[c][k] <= '0;
      end
    end else begin
      timer_q <= timer_d;
      frozen_q <= frozen_d;
      err_q <= err_d;
      rd_valid_q <= mon.rd_en_i;
      if (mon.rd_en_i) rd_data_q <= rd_d;
      for (int c = 0; c < NUM_CH; c++) begin
        wp_q[c] <= wp_d[c];
        rp_q[c] <= rp_d[c];
        oc_q[c] <= oc_d[c];
        sc_q[c] <= sc_d[c];
        dc_q[c] <= dc_d[c];
        stc_q[c] <= stc_d[c];
        ll_q[c] <= ll_d[c];
        st_q[c] <= st_d[c];
`ifdef DF_MON_MINMAX_EN
        mn_q[c] <= mn_d[c];
        mx_q[c] <= mx_d[c];
`endif
        if (push[c]) ts_q[c][wp_q[c]] <= timer_q;
      end
    end
endmodule

// File: tb/tb_ap_ctrl_multi_monitor.sv
// tb_ap_ctrl_multi_monitor: directed self-checking bench for ap_ctrl_multi_monitor (3 channels, depth 8)
module tb_ap_ctrl_multi_monitor;
  localparam int NCH = 3;
`ifdef DF_MON_MINMAX_EN
  localparam bit MM = 1'b1;
`else
  localparam bit MM = 1'b0;
`endif
  localparam logic [31:0] MIN_RST = MM ? 32'hFFFF_FFFF : 32'd0;
  logic clock = 1'b0, reset_n = 1'b0, finish_i = 1'b0, clear_i = 1'b0;
  int checks = 0, errors = 0;
  ap_ctrl_multi_monitor_if #(.NUM_CH(NCH), .CNT_W(32)) m ();
  ap_ctrl_multi_monitor #(.NUM_CH(NCH), .CNT_W(32), .MAX_OUTST(8)) dut (
    .clock(clock), .reset_n(reset_n), .finish_i(finish_i), .clear_i(clear_i), .mon(m)
  );
  always #5 clock = ~clock;
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic rd(input int ch, input int sel, output logic [31:0] d);
    m.rd_en_i = 1'b1;
    m.rd_ch_i = 2'(ch);
    m.rd_sel_i = 3'(sel);
    tick();
    d = m.rd_data_o;
    m.rd_en_i = 1'b0;
  endtask
  task automatic txn(input int ch);
    m.ap_start_i[ch] = 1'b1; m.ap_ready_i[ch] = 1'b1; tick();
    m.ap_start_i[ch] = 1'b0; m.ap_ready_i[ch] = 1'b0; m.ap_done_i[ch] = 1'b1; tick();
    m.ap_done_i[ch] = 1'b0;
  endtask
  task automatic test_reset();
    logic [31:0] d;
    reset_n = 1'b0; tick(); tick(); #2 reset_n = 1'b1; tick();
    checks++; if (m.busy_o !== 3'b000) begin errors++; $display("FAIL reset_busy: got %b expected 000", m.busy_o); end
    checks++; if (m.err_o !== 3'b000) begin errors++; $display("FAIL reset_err: got %b expected 000", m.err_o); end
    checks++; if (m.rd_valid_o !== 1'b0 || m.rd_data_o !== 32'd0) begin errors++; $display("FAIL reset_rd: valid %b data %0h expected 0/0", m.rd_valid_o, m.rd_data_o); end
    rd(0, 4, d);
    checks++; if (m.rd_valid_o !== 1'b1) begin errors++; $display("FAIL rd_valid: got %b expected 1", m.rd_valid_o); end
    checks++; if (d !== MIN_RST) begin errors++; $display("FAIL reset_min: got %0h expected %0h", d, MIN_RST); end
    rd(0, 0, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_start: got %0d expected 0", d); end
    tick();
    checks++; if (m.rd_valid_o !== 1'b0) begin errors++; $display("FAIL rd_valid_idle: got %b expected 0", m.rd_valid_o); end
  endtask
  task automatic test_single();
    logic [31:0] d;
    m.ap_start_i[0] = 1'b1; tick(); tick();
    checks++; if (m.busy_o[0] !== 1'b0) begin errors++; $display("FAIL single_no_accept: busy %b expected 0", m.busy_o[0]); end
    m.ap_ready_i[0] = 1'b1; tick();
    m.ap_start_i[0] = 1'b0; m.ap_ready_i[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (m.busy_o[0] !== 1'b1) begin errors++; $display("FAIL single_busy%0d: got %b expected 1", i, m.busy_o[0]); end
      tick();
    end
    m.ap_done_i[0] = 1'b1; tick(); m.ap_done_i[0] = 1'b0;
    checks++; if (m.busy_o[0] !== 1'b0) begin errors++; $display("FAIL single_idle: got %b expected 0", m.busy_o[0]); end
    rd(0, 0, d); checks++; if (d !== 32'd1) begin errors++; $display("FAIL single_start: got %0d expected 1", d); end
    rd(0, 1, d); checks++; if (d !== 32'd1) begin errors++; $display("FAIL single_done: got %0d expected 1", d); end
    rd(0, 2, d); checks++; if (d !== 32'd5) begin errors++; $display("FAIL single_lat: got %0d expected 5", d); end
    rd(0, 5, d); checks++; if (d !== (MM ? 32'd5 : 32'd0)) begin errors++; $display("FAIL single_max: got %0d expected %0d", d, MM ? 5 : 0); end
  endtask
  task automatic test_pipelined();
    logic [31:0] d;
    m.ap_start_i[1] = 1'b1; m.ap_ready_i[1] = 1'b1; tick(); tick();
    m.rd_en_i = 1'b1; m.rd_ch_i = 2'd1; m.rd_sel_i = 3'd6; tick();
    m.rd_en_i = 1'b0; m.ap_start_i[1] = 1'b0; m.ap_ready_i[1] = 1'b0;
    checks++; if (m.rd_data_o !== 32'd3) begin errors++; $display("FAIL pipe_outst3: got %0d expected 3", m.rd_data_o); end
    checks++; if (m.busy_o[1] !== 1'b1) begin errors++; $display("FAIL pipe_busy: got %b expected 1", m.busy_o[1]); end
    tick(); tick(); tick();
    m.ap_done_i[1] = 1'b1; tick(); tick(); tick(); m.ap_done_i[1] = 1'b0;
    checks++; if (m.busy_o[1] !== 1'b0) begin errors++; $display("FAIL pipe_idle: got %b expected 0", m.busy_o[1]); end
    rd(1, 1, d); checks++; if (d !== 32'd3) begin errors++; $display("FAIL pipe_done: got %0d expected 3", d); end
    rd(1, 2, d); checks++; if (d !== 32'd6) begin errors++; $display("FAIL pipe_lat: got %0d expected 6", d); end
    rd(1, 6, d); checks++; if (d !== 32'd0) begin errors++; $display("FAIL pipe_outst0: got %0d expected 0", d); end
    rd(1, 4, d); checks++; if (d !== (MM ? 32'd6 : 32'd0)) begin errors++; $display("FAIL pipe_min: got %0d expected %0d", d, MM ? 6 : 0); end
    rd(1, 5, d); checks++; if (d !== (MM ? 32'd6 : 32'd0)) begin errors++; $display("FAIL pipe_max: got %0d expected %0d", d, MM ? 6 : 0); end
  endtask
  task automatic test_stall();
    logic [31:0] d;
    m.ap_start_i[2] = 1'b1; m.ap_ready_i[2] = 1'b1; tick();
    m.ap_start_i[2] = 1'b0; m.ap_ready_i[2] = 1'b0;
    m.ap_done_i[2] = 1'b1; m.ap_continue_i[2] = 1'b0; tick(); tick(); tick();
    m.rd_en_i = 1'b1; m.rd_ch_i = 2'd2; m.rd_sel_i = 3'd7; tick();
    checks++; if (m.rd_data_o !== 32'd9) begin errors++; $display("FAIL stall_status: got %0h expected 9", m.rd_data_o); end
    checks++; if (m.busy_o[2] !== 1'b1) begin errors++; $display("FAIL stall_busy: got %b expected 1", m.busy_o[2]); end
    m.ap_continue_i[2] = 1'b1; m.rd_sel_i = 3'd3; tick();
    m.rd_en_i = 1'b0; m.ap_done_i[2] = 1'b0;
    checks++; if (m.rd_data_o !== 32'd4) begin errors++; $display("FAIL stall_cnt: got %0d expected 4", m.rd_data_o); end
    checks++; if (m.busy_o[2] !== 1'b0) begin errors++; $display("FAIL stall_idle: got %b expected 0", m.busy_o[2]); end
    rd(2, 7, d); checks++; if (d !== 32'd0) begin errors++; $display("FAIL stall_status_idle: got %0h expected 0", d); end
    rd(2, 2, d); checks++; if (d !== 32'd5) begin errors++; $display("FAIL stall_lat: got %0d expected 5", d); end
  endtask
  task automatic test_errors();
    logic [31:0] d;
    m.ap_done_i[0] = 1'b1; tick(); m.ap_done_i[0] = 1'b0;
    checks++; if (m.err_o !== 3'b001) begin errors++; $display("FAIL err_empty: got %b expected 001", m.err_o); end
    rd(0, 1, d); checks++; if (d !== 32'd1) begin errors++; $display("FAIL err_done_cnt: got %0d expected 1", d); end
    rd(0, 7, d); checks++; if (d !== 32'd2) begin errors++; $display("FAIL err_status: got %0h expected 2", d); end
    m.ap_start_i[1] = 1'b1; m.ap_ready_i[1] = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    checks++; if (m.err_o !== 3'b001) begin errors++; $display("FAIL err_full8: got %b expected 001", m.err_o); end
    tick(); m.ap_start_i[1] = 1'b0; m.ap_ready_i[1] = 1'b0;
    checks++; if (m.err_o !== 3'b011) begin errors++; $display("FAIL err_full9: got %b expected 011", m.err_o); end
    rd(1, 0, d); checks++; if (d !== 32'd12) begin errors++; $display("FAIL err_start_cnt: got %0d expected 12", d); end
    rd(1, 6, d); checks++; if (d !== 32'd8) begin errors++; $display("FAIL err_outst: got %0d expected 8", d); end
    m.ap_start_i[2] = 1'b1; m.ap_ready_i[2] = 1'b1; m.ap_done_i[2] = 1'b1; tick();
    m.ap_start_i[2] = 1'b0; m.ap_ready_i[2] = 1'b0; m.ap_done_i[2] = 1'b0;
    checks++; if (m.err_o !== 3'b011 || m.busy_o[2] !== 1'b0) begin errors++; $display("FAIL passthru_flags: err %b busy %b expected 011/0", m.err_o, m.busy_o[2]); end
    rd(2, 1, d); checks++; if (d !== 32'd2) begin errors++; $display("FAIL passthru_done: got %0d expected 2", d); end
    rd(2, 2, d); checks++; if (d !== 32'd0) begin errors++; $display("FAIL passthru_lat: got %0d expected 0", d); end
    rd(2, 4, d); checks++; if (d !== 32'd0) begin errors++; $display("FAIL passthru_min: got %0d expected 0", d); end
    rd(2, 5, d); checks++; if (d !== (MM ? 32'd5 : 32'd0)) begin errors++; $display("FAIL passthru_max: got %0d expected %0d", d, MM ? 5 : 0); end
  endtask
  task automatic test_freeze_clear();
    logic [31:0] d;
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    checks++; if (m.err_o !== 3'b000 || m.busy_o !== 3'b000) begin errors++; $display("FAIL clear_flags: err %b busy %b expected 000/000", m.err_o, m.busy_o); end
    rd(1, 0, d); checks++; if (d !== 32'd0) begin errors++; $display("FAIL clear_start: got %0d expected 0", d); end
    rd(1, 6, d); checks++; if (d !== 32'd0) begin errors++; $display("FAIL clear_outst: got %0d expected 0", d); end
    txn(0); txn(0);
    finish_i = 1'b1; tick(); finish_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m.ap_start_i[0] = 1'b1; m.ap_ready_i[0] = 1'b1; tick();
      m.ap_start_i[0] = 1'b0; m.ap_ready_i[0] = 1'b0;
      checks++; if (m.busy_o[0] !== 1'b0) begin errors++; $display("FAIL frozen_busy%0d: got %b expected 0", i, m.busy_o[0]); end
      m.ap_done_i[0] = 1'b1; tick(); m.ap_done_i[0] = 1'b0;
    end
    rd(0, 1, d); checks++; if (d !== 32'd2) begin errors++; $display("FAIL frozen_done: got %0d expected 2", d); end
    rd(0, 0, d); checks++; if (d !== 32'd2) begin errors++; $display("FAIL frozen_start: got %0d expected 2", d); end
    rd(0, 2, d); checks++; if (d !== 32'd1) begin errors++; $display("FAIL frozen_lat: got %0d expected 1", d); end
    rd(0, 4, d); checks++; if (d !== (MM ? 32'd1 : 32'd0)) begin errors++; $display("FAIL frozen_min: got %0d expected %0d", d, MM ? 1 : 0); end
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    rd(0, 1, d); checks++; if (d !== 32'd0) begin errors++; $display("FAIL clear2_done: got %0d expected 0", d); end
    rd(0, 4, d); checks++; if (d !== MIN_RST) begin errors++; $display("FAIL clear2_min: got %0h expected %0h", d, MIN_RST); end
    txn(0);
    rd(0, 0, d); checks++; if (d !== 32'd1) begin errors++; $display("FAIL unfrozen_start: got %0d expected 1", d); end
  endtask
  task automatic test_reset_mid();
    logic [31:0] d;
    m.ap_start_i[1] = 1'b1; m.ap_ready_i[1] = 1'b1; tick(); tick();
    m.ap_start_i[1] = 1'b0; m.ap_ready_i[1] = 1'b0;
    rd(1, 6, d); checks++; if (d !== 32'd2) begin errors++; $display("FAIL mid_outst: got %0d expected 2", d); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (m.busy_o !== 3'b000) begin errors++; $display("FAIL mid_busy: got %b expected 000", m.busy_o); end
    checks++; if (m.rd_valid_o !== 1'b0 || m.rd_data_o !== 32'd0) begin errors++; $display("FAIL mid_rd: valid %b data %0h expected 0/0", m.rd_valid_o, m.rd_data_o); end
    #1 reset_n = 1'b1;
    tick();
    rd(1, 0, d); checks++; if (d !== 32'd0) begin errors++; $display("FAIL mid_start: got %0d expected 0", d); end
    txn(1);
    rd(1, 0, d); checks++; if (d !== 32'd1) begin errors++; $display("FAIL mid_start_after: got %0d expected 1", d); end
    rd(3, 0, d); checks++; if (d !== 32'd0) begin errors++; $display("FAIL bad_ch: got %0d expected 0", d); end
  endtask
  initial begin
    m.ap_start_i = '0; m.ap_ready_i = '0; m.ap_done_i = '0; m.ap_continue_i = '1;
    m.rd_en_i = 1'b0; m.rd_ch_i = '0; m.rd_sel_i = '0;
    test_reset();
    test_single();
    test_pipelined();
    test_stall();
    test_errors();
    test_freeze_clear();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
